// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide/remainder unit.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package div_pkg;

    // Matches funct3[1:0] of the RV32M divide group.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam int          DIV_ITERS   = 32;
    localparam logic [31:0] OVF_PATTERN = 32'h8000_0000;

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic op_is_rem(input op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   rem_in / quo_in   partial remainder and quotient/dividend shift register
//   divisor           unsigned divisor magnitude
//   rem_out / quo_out values after one shift-and-trial-subtract
module div_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);

    // The shifted remainder can reach 2*divisor-1, so the trial is 33 bits
    // wide; bit 32 of the difference is the borrow.
    logic [32:0] rem_sh;
    logic [32:0] diff;

    always_comb begin
        rem_sh = {rem_in, quo_in[31]};
        diff   = rem_sh - {1'b0, divisor};
        if (diff[32]) begin
            rem_out = rem_sh[31:0];
        end else begin
            rem_out = diff[31:0];
        end
        quo_out = {quo_in[30:0], ~diff[32]};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU/REM/REMU unit, restoring algorithm, one step per cycle.
// Latency: 33 cycles start-to-done; 1 cycle for divide-by-zero/overflow when DIV_EARLY_OUT_EN is defined.
// Backpressure: busy is high while working; start is ignored while busy.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start, op         request and operation (op_e encoding), sampled only when idle
//   input1, input2    dividend, divisor
//   busy              high from the accepted start until the done cycle
//   done, out         one-cycle done pulse; out valid from done and held afterwards
//
// Optional feature macro: DIV_EARLY_OUT_EN (short-circuit the special cases).
module div_unit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    state_e      state;
    op_e         op_q;
    logic        dvd_neg;
    logic        dvs_neg;
    logic        div0_q;
    logic        ovf_q;
    logic [31:0] dvd_raw;
    logic [31:0] divisor_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [4:0]  iter_q;

    // Request decode, used only in IDLE.
    op_e         op_in;
    logic        in_signed;
    logic        in_neg1;
    logic        in_neg2;
    logic [31:0] in_abs1;
    logic [31:0] in_abs2;
    logic        in_div0;
    logic        in_ovf;

    always_comb begin
        op_in     = op_e'(op);
        in_signed = op_is_signed(op_in);
        in_neg1   = in_signed & input1[31];
        in_neg2   = in_signed & input2[31];
        in_abs1   = in_neg1 ? -input1 : input1;
        in_abs2   = in_neg2 ? -input2 : input2;
        in_div0   = (input2 == 32'd0);
        in_ovf    = in_signed && (input1 == OVF_PATTERN) && (input2 == 32'hFFFF_FFFF);
    end

    logic [31:0] step_rem;
    logic [31:0] step_quo;

    div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Sign fix-up and special-case override, registered in FIX.
    logic [31:0] q_signed;
    logic [31:0] r_signed;
    logic [31:0] fix_result;

    always_comb begin
        q_signed = (dvd_neg ^ dvs_neg) ? -quo_q : quo_q;
        r_signed = dvd_neg ? -rem_q : rem_q;
        if (div0_q) begin
            fix_result = op_is_rem(op_q) ? dvd_raw : 32'hFFFF_FFFF;
        end else if (ovf_q) begin
            fix_result = op_is_rem(op_q) ? 32'd0 : OVF_PATTERN;
        end else begin
            fix_result = op_is_rem(op_q) ? r_signed : q_signed;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_DIV;
            dvd_neg   <= 1'b0;
            dvs_neg   <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dvd_raw   <= 32'd0;
            divisor_q <= 32'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            iter_q    <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op_in;
                        dvd_neg   <= in_neg1;
                        dvs_neg   <= in_neg2;
                        div0_q    <= in_div0;
                        ovf_q     <= in_ovf;
                        dvd_raw   <= input1;
                        divisor_q <= in_abs2;
                        quo_q     <= in_abs1;
                        rem_q     <= 32'd0;
                        iter_q    <= 5'd0;
                        busy      <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        state     <= (in_div0 || in_ovf) ? ST_FIX : ST_CALC;
`else
                        state     <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    rem_q  <= step_rem;
                    quo_q  <= step_quo;
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == 5'(DIV_ITERS - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    out   <= fix_result;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: vector table plus corner-case sequences.
// Latency: expects 33 cycles start-to-done, 1 for special cases with DIV_EARLY_OUT_EN.
// Backpressure: exercises start-while-busy and mid-operation reset.
module tb_div_unit;
    import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int FULL_LAT = 33;
    localparam int NVEC     = 14;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [31:0] dut_out;

    int n_cmp;
    int n_fail;

    div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .input1  (input1),
        .input2  (input2),
        .busy    (busy),
        .done    (done),
        .out     (dut_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [0:NVEC-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request; poke_at>0 re-pulses start with other operands at that
    // cycle count while the unit is busy. Returns result and measured latency.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, input string tag,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; input1 = a; input2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        lat = 0;
        res = 32'hDEAD_BEEF;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                res = dut_out;
                chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
                break;
            end
            if (lat == poke_at) begin
                op = OP_DIVU; input1 = 32'd1000; input2 = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (lat >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", tag, lat);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, "_out_held"}, dut_out, res);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        saw;

        n_cmp  = 0;
        n_fail = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        input1  = 32'd0;
        input2  = 32'd0;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         FULL_LAT};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          FULL_LAT};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  FULL_LAT};
        vecs[3]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  FULL_LAT};
        vecs[4]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  FULL_LAT};
        vecs[5]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPEC_LAT};
        vecs[6]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          SPEC_LAT};
        vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPEC_LAT};
        vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPEC_LAT};
        vecs[9]  = '{OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  FULL_LAT};
        vecs[10] = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          FULL_LAT};
        vecs[11] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  SPEC_LAT};
        vecs[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          FULL_LAT};
        vecs[13] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  FULL_LAT};

        // Reset state
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_out",  dut_out,       32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, $sformatf("vec%0d", i), res, lat);
            chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Start re-pulsed mid-operation must be ignored.
        do_op(OP_DIVU, 32'd100, 32'd7, 10, "ignore", res, lat);
        chk("ignore_out", res, 32'd14);
        chk("ignore_latency", 32'(lat), 32'(FULL_LAT));
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw = 1'b1;
        end
        chk("ignore_no_second_done", {31'd0, saw}, 32'd0);

        // Reset in the middle of an operation aborts it immediately.
        @(negedge clk);
        op = OP_DIVU; input1 = 32'd1000; input2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_out",  dut_out,       32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1'b1;
        end
        chk("midreset_no_done", {31'd0, saw}, 32'd0);

        // Recovery after the aborted operation.
        do_op(OP_DIVU, 32'd1000, 32'd3, 0, "recover", res, lat);
        chk("recover_out", res, 32'd333);
        chk("recover_latency", 32'(lat), 32'(FULL_LAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
